// File: rtl/rename_map_table_if.sv
// Rename-stage bundle between decode/free list, ROB walk-back, writeback and the alias table.
// The table side (slave) returns lookups and the rename stall combinationally.
interface rename_map_table_if #(
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6
);
    logic              rename_en;
    logic [ARCH_W-1:0] l_rs;
    logic [ARCH_W-1:0] l_rt;
    logic [ARCH_W-1:0] l_rd;
    logic [PHYS_W-1:0] p_rd_new;
    logic              fl_empty;
    logic              stall_recover;
    logic              recover;
    logic [ARCH_W-1:0] rec_l_rd;
    logic [PHYS_W-1:0] rec_p_rd_old;
    logic              wb_en;
    logic [PHYS_W-1:0] wb_p_rd;
    logic [PHYS_W-1:0] p_rs;
    logic [PHYS_W-1:0] p_rt;
    logic [PHYS_W-1:0] p_rd_old;
    logic              p_rs_rdy;
    logic              p_rt_rdy;
    logic              rename_stall;

    modport master (
        output rename_en, l_rs, l_rt, l_rd, p_rd_new, fl_empty, stall_recover,
               recover, rec_l_rd, rec_p_rd_old, wb_en, wb_p_rd,
        input  p_rs, p_rt, p_rd_old, p_rs_rdy, p_rt_rdy, rename_stall
    );

    modport slave (
        input  rename_en, l_rs, l_rt, l_rd, p_rd_new, fl_empty, stall_recover,
               recover, rec_l_rd, rec_p_rd_old, wb_en, wb_p_rd,
        output p_rs, p_rt, p_rd_old, p_rs_rdy, p_rt_rdy, rename_stall
    );
endinterface

// File: rtl/rename_map_table.sv
// Register alias table with per-PR ready bits and ROB walk-back restore.
// Latency: lookups combinational from the pre-edge map; updates land at the next rising edge.
// Backpressure: rename_stall when free list empty or recovery pending/active; writeback never blocked.
module rename_map_table #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_W    = 5,
    parameter int PHYS_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    rename_map_table_if.slave rif
);

    logic [PHYS_W-1:0]    map_q [ARCH_REGS];
    logic [PHYS_REGS-1:0] ready_q;
    logic [PHYS_REGS-1:0] ready_d;
    logic [PHYS_W-1:0]    p_rs;
    logic [PHYS_W-1:0]    p_rt;
    logic                 rename_stall;
    logic                 rename_do;

    assign p_rs = map_q[rif.l_rs];
    assign p_rt = map_q[rif.l_rt];

    assign rename_stall = rif.rename_en & (rif.fl_empty | rif.stall_recover | rif.recover);
    assign rename_do    = rif.rename_en & ~rename_stall;

    assign rif.p_rs         = p_rs;
    assign rif.p_rt         = p_rt;
    assign rif.p_rd_old     = map_q[rif.l_rd];
    assign rif.rename_stall = rename_stall;
    // Same-cycle writeback bypasses the ready table so a consumer need not wait an edge.
    assign rif.p_rs_rdy     = ready_q[p_rs] | (rif.wb_en & (rif.wb_p_rd == p_rs));
    assign rif.p_rt_rdy     = ready_q[p_rt] | (rif.wb_en & (rif.wb_p_rd == p_rt));

    // Allocation clear is applied after the writeback set so it wins on a collision.
    always_comb begin
        ready_d = ready_q;
        if (rif.wb_en) begin
            ready_d[rif.wb_p_rd] = 1'b1;
        end
        if (rename_do) begin
            ready_d[rif.p_rd_new] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    // rename_do is already low while recover is high, so the two writes never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
        end else if (rif.recover) begin
            map_q[rif.rec_l_rd] <= rif.rec_p_rd_old;
        end else if (rename_do) begin
            map_q[rif.l_rd] <= rif.p_rd_new;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed vector table, reset-mid-recovery sequence,
// then randomized traffic against an array-based reference of the alias and ready tables.
module tb_rename_map_table;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rename_map_table_if #(.ARCH_W(5), .PHYS_W(6)) rif ();

    rename_map_table #(
        .ARCH_REGS(32), .PHYS_REGS(64), .ARCH_W(5), .PHYS_W(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rif (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int re;  int l_rs; int l_rt; int l_rd; int p_new;
        int fe;  int sr;   int rc;   int rec_l; int rec_p;
        int wb;  int wb_p;
        int e_rs; int e_rt; int e_old; int e_rsr; int e_rtr; int e_st;
    } vec_t;

    vec_t tbl [18];

    // Reference state: logical->physical map and per-PR ready flags.
    int m_map [32];
    bit m_rdy [64];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int re, input int l_rs, input int l_rt, input int l_rd,
                         input int p_new, input int fe, input int sr, input int rc,
                         input int rec_l, input int rec_p, input int wb, input int wb_p);
        rif.rename_en     = re[0];
        rif.l_rs          = l_rs[4:0];
        rif.l_rt          = l_rt[4:0];
        rif.l_rd          = l_rd[4:0];
        rif.p_rd_new      = p_new[5:0];
        rif.fl_empty      = fe[0];
        rif.stall_recover = sr[0];
        rif.recover       = rc[0];
        rif.rec_l_rd      = rec_l[4:0];
        rif.rec_p_rd_old  = rec_p[5:0];
        rif.wb_en         = wb[0];
        rif.wb_p_rd       = wb_p[5:0];
    endtask

    task automatic check_outs(input string tag, input int e_rs, input int e_rt, input int e_old,
                              input int e_rsr, input int e_rtr, input int e_st);
        chk({tag, " p_rs"},         int'(rif.p_rs),         e_rs);
        chk({tag, " p_rt"},         int'(rif.p_rt),         e_rt);
        chk({tag, " p_rd_old"},     int'(rif.p_rd_old),     e_old);
        chk({tag, " p_rs_rdy"},     int'(rif.p_rs_rdy),     e_rsr);
        chk({tag, " p_rt_rdy"},     int'(rif.p_rt_rdy),     e_rtr);
        chk({tag, " rename_stall"}, int'(rif.rename_stall), e_st);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //        re l_rs l_rt l_rd new fe sr rc recl recp wb wbp   rs  rt old rsr rtr st
        tbl[0]  = '{0, 3,   7,  31,  0,  0, 0, 0, 0,  0,   0, 0,    3,  7, 31, 1,  1,  0};
        tbl[1]  = '{1, 5,   0,   5, 32,  0, 0, 0, 0,  0,   0, 0,    5,  0,  5, 1,  1,  0};
        tbl[2]  = '{0, 5,   5,   5,  0,  0, 0, 0, 0,  0,   0, 0,   32, 32, 32, 0,  0,  0};
        tbl[3]  = '{0, 5,   5,   5,  0,  0, 0, 0, 0,  0,   1, 32,  32, 32, 32, 1,  1,  0};
        tbl[4]  = '{0, 5,   5,   5,  0,  0, 0, 0, 0,  0,   0, 0,   32, 32, 32, 1,  1,  0};
        tbl[5]  = '{1, 5,   5,   5, 33,  0, 0, 0, 0,  0,   0, 0,   32, 32, 32, 1,  1,  0};
        tbl[6]  = '{1, 5,   5,   5, 34,  0, 0, 0, 0,  0,   0, 0,   33, 33, 33, 0,  0,  0};
        tbl[7]  = '{0, 5,   5,   5,  0,  0, 0, 0, 0,  0,   0, 0,   34, 34, 34, 0,  0,  0};
        tbl[8]  = '{1, 9,   5,   9, 40,  1, 0, 0, 0,  0,   0, 0,    9, 34,  9, 1,  0,  1};
        tbl[9]  = '{0, 9,   9,   9,  0,  0, 0, 0, 0,  0,   0, 0,    9,  9,  9, 1,  1,  0};
        tbl[10] = '{1, 6,   5,   6, 35,  0, 0, 0, 0,  0,   0, 0,    6, 34,  6, 1,  0,  0};
        tbl[11] = '{1, 6,   5,   7, 41,  0, 1, 0, 0,  0,   1, 34,  35, 34,  7, 0,  1,  1};
        tbl[12] = '{1, 6,   5,   7, 41,  0, 0, 1, 6,  6,   0, 0,   35, 34,  7, 0,  1,  1};
        tbl[13] = '{1, 6,   5,   5, 41,  0, 0, 1, 5, 33,   0, 0,    6, 34, 34, 1,  1,  1};
        tbl[14] = '{1, 5,   6,   5, 41,  0, 0, 1, 5, 32,   0, 0,   33,  6, 33, 0,  1,  1};
        tbl[15] = '{0, 5,   6,   7,  0,  0, 0, 0, 0,  0,   0, 0,   32,  6,  7, 1,  1,  0};
        tbl[16] = '{1, 7,   7,   7, 41,  0, 0, 0, 0,  0,   0, 0,    7,  7,  7, 1,  1,  0};
        tbl[17] = '{0, 7,   7,   7,  0,  0, 0, 0, 0,  0,   0, 0,   41, 41, 41, 0,  0,  0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].re, tbl[i].l_rs, tbl[i].l_rt, tbl[i].l_rd, tbl[i].p_new,
                  tbl[i].fe, tbl[i].sr, tbl[i].rc, tbl[i].rec_l, tbl[i].rec_p,
                  tbl[i].wb, tbl[i].wb_p);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].e_rs, tbl[i].e_rt, tbl[i].e_old,
                       tbl[i].e_rsr, tbl[i].e_rtr, tbl[i].e_st);
            next_cycle();
        end

        // Reset dropped in the middle of a walk-back: identity returns at once.
        drive(0, 5, 7, 6, 0, 0, 0, 1, 5, 33, 0, 0);
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst_mid", 5, 7, 6, 1, 1, 0);
        next_cycle();
        rst = 1'b1;
        drive(1, 2, 5, 2, 36, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_outs("post_rst_ren", 2, 5, 2, 1, 1, 0);
        next_cycle();
        drive(0, 2, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_outs("post_rst_map", 36, 5, 36, 0, 1, 0);
        next_cycle();

        // Randomized traffic against the reference tables.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_map[i] = i;
        for (int j = 0; j < 64; j++) m_rdy[j] = 1'b1;
        next_cycle();

        for (int c = 0; c < 500; c++) begin
            int re, l_rs, l_rt, l_rd, p_new, fe, sr, rc, rec_l, rec_p, wb, wb_p;
            int e_rs, e_rt, e_st;
            bit renames;
            re    = ($urandom_range(3) != 0) ? 1 : 0;
            l_rs  = $urandom_range(31);
            l_rt  = $urandom_range(31);
            l_rd  = $urandom_range(31);
            p_new = $urandom_range(63);
            fe    = ($urandom_range(7) == 0) ? 1 : 0;
            sr    = ($urandom_range(7) == 0) ? 1 : 0;
            rc    = ($urandom_range(5) == 0) ? 1 : 0;
            rec_l = $urandom_range(31);
            rec_p = $urandom_range(63);
            wb    = $urandom_range(1);
            wb_p  = $urandom_range(63);

            e_st    = (re != 0 && (fe != 0 || sr != 0 || rc != 0)) ? 1 : 0;
            renames = (re != 0 && e_st == 0);
            // Writeback and allocation of one PR in one cycle is illegal; keep it out of the stream.
            if (renames && wb != 0 && wb_p == p_new) wb = 0;

            drive(re, l_rs, l_rt, l_rd, p_new, fe, sr, rc, rec_l, rec_p, wb, wb_p);
            e_rs = m_map[l_rs];
            e_rt = m_map[l_rt];
            @(negedge clk);
            check_outs($sformatf("rnd%0d", c), e_rs, e_rt, m_map[l_rd],
                       (m_rdy[e_rs] || (wb != 0 && wb_p == e_rs)) ? 1 : 0,
                       (m_rdy[e_rt] || (wb != 0 && wb_p == e_rt)) ? 1 : 0,
                       e_st);
            next_cycle();

            if (wb != 0) m_rdy[wb_p] = 1'b1;
            if (renames) m_rdy[p_new] = 1'b0;
            if (rc != 0)      m_map[rec_l] = rec_p;
            else if (renames) m_map[l_rd]  = p_new;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
